// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster-order pixel stream into every fully
// populated 3x3 window (valid convolution, stride 1, no padding).
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   clear             synchronous frame abort (beats in_valid in the same cycle)
//   in_valid, in_data accepted pixel, no backpressure
//   win_valid         one-cycle strobe, win_d1..win_d9 hold a new window
//   win_d1..win_d9    window pixels in row-major order (d1 top-left, d9 bottom-right)
//   frame_done        pulses with the last window of the frame
//   busy              high while the FSM is in FILL or STREAM
module conv_window_gen #(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              win_valid,
    output logic [DATA_W-1:0] win_d1,
    output logic [DATA_W-1:0] win_d2,
    output logic [DATA_W-1:0] win_d3,
    output logic [DATA_W-1:0] win_d4,
    output logic [DATA_W-1:0] win_d5,
    output logic [DATA_W-1:0] win_d6,
    output logic [DATA_W-1:0] win_d7,
    output logic [DATA_W-1:0] win_d8,
    output logic [DATA_W-1:0] win_d9,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_e;

    // Window arrays are indexed [row][col], row 0 on top, col 0 on the left.
    typedef logic [2:0][2:0][DATA_W-1:0] win_t;

    state_e            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    win_t              win_q, win_d;
    win_t              out_q, out_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];

    logic accept;
    logic last_col;
    logic last_row;

    assign accept   = in_valid && !clear;
    assign last_col = (col_q == COL_W'(IMG_W - 1));
    assign last_row = (row_q == ROW_W'(IMG_H - 1));

    // Next-state: counters, FSM, window shift and output capture.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        out_d   = out_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        if (clear) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
        end else if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            // Line buffers are read before this cycle's write lands.
            win_d[0][2] = lb1[col_q];
            win_d[1][2] = lb0[col_q];
            win_d[2][2] = in_data;

            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            unique case (state_q)
                IDLE:    state_d = FILL;
                FILL:    if (row_q == ROW_W'(2) && col_q == '0) state_d = STREAM;
                STREAM:  if (last_col && last_row) state_d = IDLE;
                default: state_d = IDLE;
            endcase

            // Gating on row/col keeps stale line-buffer data out of any window.
            if (row_q >= ROW_W'(2) && col_q >= COL_W'(2)) begin
                valid_d = 1'b1;
                out_d   = win_d;
                done_d  = last_col && last_row;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Line buffers: lb0 holds the previous row, lb1 the one before it.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_q] <= lb0[col_q];
            lb0[col_q] <= in_data;
        end
    end

    assign win_valid  = valid_q;
    assign frame_done = done_q;
    assign busy       = busy_q;
    assign win_d1     = out_q[0][0];
    assign win_d2     = out_q[0][1];
    assign win_d3     = out_q[0][2];
    assign win_d4     = out_q[1][0];
    assign win_d5     = out_q[1][1];
    assign win_d6     = out_q[1][2];
    assign win_d7     = out_q[2][0];
    assign win_d8     = out_q[2][1];
    assign win_d9     = out_q[2][2];

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 4x4 and a 5x3 instance, driven by directed
// frames and random traffic, checked by a queue-based scoreboard against a
// frame-array reference model.
module tb_conv_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clear;
    logic       v4, v5;
    logic [7:0] d4, d5;
    logic       wv4, fd4, bz4, wv5, fd5, bz5;
    logic [8:0][7:0] o4, o5;   // {d1..d9}, d1 in the top byte

    conv_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(v4), .in_data(d4),
        .win_valid(wv4),
        .win_d1(o4[8]), .win_d2(o4[7]), .win_d3(o4[6]),
        .win_d4(o4[5]), .win_d5(o4[4]), .win_d6(o4[3]),
        .win_d7(o4[2]), .win_d8(o4[1]), .win_d9(o4[0]),
        .frame_done(fd4), .busy(bz4)
    );

    conv_window_gen #(.IMG_W(5), .IMG_H(3), .DATA_W(8)) dut5 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(v5), .in_data(d5),
        .win_valid(wv5),
        .win_d1(o5[8]), .win_d2(o5[7]), .win_d3(o5[6]),
        .win_d4(o5[5]), .win_d5(o5[4]), .win_d6(o5[3]),
        .win_d7(o5[2]), .win_d8(o5[1]), .win_d9(o5[0]),
        .frame_done(fd5), .busy(bz5)
    );

    typedef struct {
        int          due;
        logic [71:0] win;
        bit          fd;
    } exp_t;

    exp_t q4[$];
    exp_t q5[$];

    int vecs = 0;
    int errs = 0;
    int pcnt = 0;
    int n4 = 0;
    int n5 = 0;

    // Reference model: current frame stored as a raster array per instance.
    logic [7:0] pix [2][16];
    int idx [2];
    int W [2];
    int H [2];

    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic accept_px(input int k, input logic [7:0] dat);
        int r, c;
        exp_t e;
        r = idx[k] / W[k];
        c = idx[k] % W[k];
        pix[k][idx[k]] = dat;
        if (r >= 2 && c >= 2) begin
            e.due = pcnt + 1;
            e.win = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win = {e.win[63:0], pix[k][(r - 2 + i) * W[k] + (c - 2 + j)]};
            e.fd = (idx[k] == W[k] * H[k] - 1);
            if (k == 0) q4.push_back(e);
            else        q5.push_back(e);
        end
        idx[k] = (idx[k] + 1) % (W[k] * H[k]);
    endtask

    // One cycle of stimulus, applied on the falling edge.
    task automatic step(input bit a4, input logic [7:0] x4, input bit a5,
                        input logic [7:0] x5, input bit clr);
        @(negedge clk);
        v4 = a4; d4 = x4; v5 = a5; d5 = x5; clear = clr;
        if (clr) begin
            idx[0] = 0;
            idx[1] = 0;
        end else begin
            if (a4) accept_px(0, x4);
            if (a5) accept_px(1, x5);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic mon(input int k);
        exp_t e;
        logic wv, fd;
        logic [71:0] w;
        wv = (k == 0) ? wv4 : wv5;
        fd = (k == 0) ? fd4 : fd5;
        w  = (k == 0) ? o4 : o5;
        if (wv) begin
            if (k == 0) n4++; else n5++;
            if ((k == 0 ? q4.size() : q5.size()) == 0) begin
                vecs++; errs++;
                $display("FAIL unexpected_strobe dut%0d: got window %0h expected none", k, w);
            end else begin
                e = (k == 0) ? q4.pop_front() : q5.pop_front();
                chk($sformatf("latency_dut%0d", k), 72'(pcnt), 72'(e.due));
                chk($sformatf("window_dut%0d", k), w, e.win);
                chk($sformatf("frame_done_dut%0d", k), 72'(fd), 72'(e.fd));
            end
        end else begin
            if (k == 0 && q4.size() > 0 && q4[0].due <= pcnt) begin
                vecs++; errs++;
                $display("FAIL missing_strobe dut0: got none expected window %0h", q4[0].win);
                void'(q4.pop_front());
            end
            if (k == 1 && q5.size() > 0 && q5[0].due <= pcnt) begin
                vecs++; errs++;
                $display("FAIL missing_strobe dut1: got none expected window %0h", q5[0].win);
                void'(q5.pop_front());
            end
            chk($sformatf("frame_done_idle_dut%0d", k), 72'(fd), 72'(0));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    int base;

    initial begin
        W = '{4, 5};
        H = '{4, 3};
        idx = '{0, 0};
        rst = 1'b1; clear = 1'b0; v4 = 1'b0; v5 = 1'b0; d4 = '0; d5 = '0;
        repeat (2) @(negedge clk);
        chk("reset_win4", o4, 72'(0));
        chk("reset_flags4", 72'({wv4, fd4, bz4}), 72'(0));
        chk("reset_flags5", 72'({wv5, fd5, bz5}), 72'(0));
        rst = 1'b0;

        // 1: one 4x4 frame, consecutive pixels
        base = n4;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 8'd0, 1'b0);
            if (i == 1) chk("busy_fill", 72'(bz4), 72'(1));
        end
        step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("busy_after_last", 72'(bz4), 72'(0));
        idle(2);
        chk("count_s1", 72'(n4 - base), 72'(4));

        // 2: same frame with a gap after every pixel
        base = n4;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 8'd0, 1'b0);
            step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        end
        idle(2);
        chk("count_s2", 72'(n4 - base), 72'(4));

        // 3: two frames back to back
        base = n4;
        for (int i = 0; i < 32; i++)
            step(1'b1, (i < 16) ? 8'(i) : 8'(i - 16 + 100), 1'b0, 8'd0, 1'b0);
        idle(2);
        chk("count_s3", 72'(n4 - base), 72'(8));

        // 4: clear after pixel 9 (with a colliding pixel that must be dropped)
        base = n4;
        for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b0, 8'd0, 1'b0);
        step(1'b1, 8'd77, 1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("busy_after_clear", 72'(bz4), 72'(0));
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i + 50), 1'b0, 8'd0, 1'b0);
        idle(2);
        chk("count_s4", 72'(n4 - base), 72'(4));

        // 5: asynchronous reset mid-stream after pixel 11
        for (int i = 0; i < 12; i++) step(1'b1, 8'(i), 1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_win4", o4, 72'(0));
        chk("async_rst_flags4", 72'({wv4, fd4, bz4}), 72'(0));
        q4.delete();
        q5.delete();
        idx = '{0, 0};
        @(negedge clk);
        rst = 1'b0;
        base = n4;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 8'd0, 1'b0);
        idle(2);
        chk("count_s5", 72'(n4 - base), 72'(4));

        // 6: 5x3 frame
        base = n5;
        for (int i = 0; i < 15; i++) step(1'b0, 8'd0, 1'b1, 8'(i), 1'b0);
        idle(2);
        chk("count_s6", 72'(n5 - base), 72'(3));

        // random traffic on both instances with gaps and occasional clear
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                 8'($urandom), $urandom_range(0, 79) == 0);
        idle(3);

        chk("drain_q4", 72'(q4.size()), 72'(0));
        chk("drain_q5", 72'(q5.size()), 72'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
